// File: rtl/wb_arbiter_rr.sv
// Wishbone N-to-1 bus arbiter: round-robin or fixed-priority grant, burst-safe hold,
// and an optional watchdog that answers a silent slave with a one-cycle bus error.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 256
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    // master side
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    // slave side
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      wb_grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [IW-1:0]   cand_idx;
    int              cand;
    logic            resp;

    assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // Winner search: rotating start after the last grant, or index 0 when fixed priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path infers a latch.
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand     = (RR_MODE != 0) ? (int'(last_q) + 1 + i) % NUM_MASTERS : i;
            cand_idx = IW'(cand);
            if (!pick_found && wbm_cyc_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = '0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    state_d = GRANT;
                    gidx_d  = pick_idx;
                end
            end
            GRANT: begin
                if (!wbm_cyc_i[gidx_q]) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog: only counts strobed cycles the slave leaves unanswered.
        if (TIMEOUT != 0 && state_q == GRANT && state_d == GRANT && wbs_stb_o && !resp) begin
            if (cnt_q == CNT_LAST) to_d = 1'b1;
            else                   cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (wb_rst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        wb_grant_o = '0;
        if (state_q == GRANT) wb_grant_o[gidx_q] = 1'b1;
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (state_q == GRANT) begin
            wbs_adr_o = wbm_adr_i[gidx_q*AW +: AW];
            wbs_dat_o = wbm_dat_i[gidx_q*DW +: DW];
            wbs_sel_o = wbm_sel_i[gidx_q*SW +: SW];
            wbs_we_o  = wbm_we_i[gidx_q];
            wbs_cyc_o = wbm_cyc_i[gidx_q];
            // The timeout cycle withdraws the strobe so the slave sees the access end.
            wbs_stb_o = wbm_stb_i[gidx_q] & ~to_q;
            wbs_cti_o = wbm_cti_i[gidx_q*3 +: 3];
            wbs_bte_o = wbm_bte_i[gidx_q*2 +: 2];
        end
    end

    always_comb begin
        wbm_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (wb_grant_o[m]) begin
                wbm_dat_o[m*DW +: DW] = wbs_dat_i;
                wbm_ack_o[m]          = wbs_ack_i;
                // A real slave response in the timeout cycle wins over the synthetic error.
                wbm_err_o[m]          = wbs_err_i | (to_q & ~resp);
                wbm_rty_o[m]          = wbs_rty_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: a round-robin instance with an 8-cycle watchdog and
// a fixed-priority instance without one share the master-side stimulus.
module tb_wb_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [N*AW-1:0]   adr;
    logic [N*DW-1:0]   dat;
    logic [N*DW/8-1:0] sel;
    logic [N-1:0]      we, cyc, stb;
    logic [N*3-1:0]    cti;
    logic [N*2-1:0]    bte;
    logic              ack_en, ack_force, slv_err, slv_rty;
    logic [DW-1:0]     slv_dat;

    logic [N*DW-1:0]   a_mdat, b_mdat;
    logic [N-1:0]      a_ack, a_err, a_rty, b_ack, b_err, b_rty, a_grant, b_grant;
    logic [AW-1:0]     a_adr, b_adr;
    logic [DW-1:0]     a_dat, b_dat;
    logic [DW/8-1:0]   a_sel, b_sel;
    logic              a_we, a_cyc, a_stb, b_we, b_cyc, b_stb;
    logic [2:0]        a_cti, b_cti;
    logic [1:0]        a_bte, b_bte;

    wire a_ack_i = (ack_en & a_stb) | ack_force;
    wire b_ack_i = (ack_en & b_stb) | ack_force;

    int checks = 0;
    int errors = 0;

    wb_arbiter_rr #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
        .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
        .wbm_dat_o(a_mdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
        .wbs_adr_o(a_adr), .wbs_dat_o(a_dat), .wbs_sel_o(a_sel), .wbs_we_o(a_we),
        .wbs_cyc_o(a_cyc), .wbs_stb_o(a_stb), .wbs_cti_o(a_cti), .wbs_bte_o(a_bte),
        .wbs_dat_i(slv_dat), .wbs_ack_i(a_ack_i), .wbs_err_i(slv_err), .wbs_rty_i(slv_rty),
        .wb_grant_o(a_grant)
    );

    wb_arbiter_rr #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(0)) u_fp (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
        .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
        .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
        .wbs_adr_o(b_adr), .wbs_dat_o(b_dat), .wbs_sel_o(b_sel), .wbs_we_o(b_we),
        .wbs_cyc_o(b_cyc), .wbs_stb_o(b_stb), .wbs_cti_o(b_cti), .wbs_bte_o(b_bte),
        .wbs_dat_i(slv_dat), .wbs_ack_i(b_ack_i), .wbs_err_i(slv_err), .wbs_rty_i(slv_rty),
        .wb_grant_o(b_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc = '0;
        stb = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    logic [2:0] burst_cti [4];

    initial begin
        burst_cti[0] = 3'b010; burst_cti[1] = 3'b010;
        burst_cti[2] = 3'b010; burst_cti[3] = 3'b111;
        rst = 1'b1;
        adr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        dat = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        sel = 8'b10_01_11_00;
        we  = 4'b1010;
        cti = '0;
        bte = 8'b00_11_10_01;
        cyc = '0;
        stb = '0;
        ack_en = 1'b1; ack_force = 1'b0; slv_err = 1'b0; slv_rty = 1'b0;
        slv_dat = 16'h5A5A;

        // Reset state, and a stray slave response while idle reaches nobody.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_grant", a_grant, 4'b0000);
        check("rst_cyc_stb", {a_cyc, a_stb}, 2'b00);
        check("rst_resp", {a_ack, a_err, a_rty}, 12'h000);
        next_cycle();
        rst = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        check("idle_drop", {a_ack, b_ack}, 8'h00);
        ack_force = 1'b0;

        // Round-robin rotation 0,1,2,3,0 with an idle cycle before each grant.
        next_cycle();
        cyc = 4'hF;
        stb = 4'hF;
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", a_grant, 64'(1) << (k % 4));
            check("rr_ack", a_ack, 64'(1) << (k % 4));
            if (k == 1) begin
                check("rr_adr", a_adr, 16'h1001);
                check("rr_dat", a_dat, 16'h00A1);
                check("rr_sel_we_bte", {a_sel, a_we, a_bte}, {2'b11, 1'b1, 2'b10});
                check("rr_mdat", a_mdat, 64'h0000_0000_5A5A_0000);
            end
            next_cycle();
            cyc[k % 4] = 1'b0;
            stb[k % 4] = 1'b0;
            @(negedge clk);
            check("rr_drop_cyc", a_cyc, 1'b0);
            next_cycle();
            cyc[k % 4] = 1'b1;
            stb[k % 4] = 1'b1;
            @(negedge clk);
            check("rr_idle", a_grant, 4'b0000);
            next_cycle();
        end

        // Fixed priority: master 1 keeps winning over 3 until it stops requesting.
        do_reset();
        cyc = 4'b1010;
        stb = 4'b1010;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fp_grant1", b_grant, 4'b0010);
            check("fp_adr", b_adr, 16'h1001);
            next_cycle();
            cyc[1] = 1'b0;
            stb[1] = 1'b0;
            next_cycle();
            cyc[1] = 1'b1;
            stb[1] = 1'b1;
            @(negedge clk);
            check("fp_idle", b_grant, 4'b0000);
            next_cycle();
        end
        @(negedge clk);
        check("fp_hold", b_grant, 4'b0010);
        next_cycle();
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        next_cycle();
        @(negedge clk);
        check("fp_idle2", b_grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("fp_grant3", b_grant, 4'b1000);

        // Burst on master 2 with a strobe gap; master 0 waits for the cycle to end.
        do_reset();
        cyc = 4'b0100;
        stb = 4'b0100;
        next_cycle();
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cti[8:6] = burst_cti[b];
            stb[2]   = 1'b1;
            @(negedge clk);
            check("burst_grant", a_grant, 4'b0100);
            check("burst_ack", a_ack, 4'b0100);
            check("burst_cti", a_cti, burst_cti[b]);
            next_cycle();
            if (b == 1) begin
                stb[2] = 1'b0;
                @(negedge clk);
                check("gap_grant", a_grant, 4'b0100);
                check("gap_stb_ack", {a_stb, a_ack}, 5'b0_0000);
                next_cycle();
            end
        end
        cyc[2] = 1'b0;
        stb[2] = 1'b0;
        cti    = '0;
        next_cycle();
        @(negedge clk);
        check("burst_idle", a_grant, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("burst_next", a_grant, 4'b0001);

        // Watchdog: silent slave, error on the 9th strobed cycle, then a response wins.
        do_reset();
        ack_en = 1'b0;
        cyc = 4'b0010;
        stb = 4'b0010;
        next_cycle();
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            check("to_wait", {a_err, a_stb}, 5'b0000_1);
            next_cycle();
        end
        @(negedge clk);
        check("to_err", a_err, 4'b0010);
        check("to_stb", a_stb, 1'b0);
        check("to_off_err", b_err, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("to_after", {a_err, a_stb}, 5'b0000_1);
        for (int s = 2; s <= 8; s++) next_cycle();
        next_cycle();
        ack_force = 1'b1;
        @(negedge clk);
        check("to_preempt_err", a_err, 4'b0000);
        check("to_preempt_ack", a_ack, 4'b0010);
        next_cycle();
        ack_force = 1'b0;
        @(negedge clk);
        check("to_quiet", a_err, 4'b0000);
        ack_en = 1'b1;

        // Reset in the middle of a master-1 transfer, then 0 and 3 compete.
        do_reset();
        cyc = 4'b0010;
        stb = 4'b0010;
        next_cycle();
        @(negedge clk);
        check("mid_grant", {a_grant, a_cyc}, 5'b0010_1);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check("mid_rst", {a_grant, a_cyc, a_stb}, 6'b0000_00);
        check("mid_rst_err", a_err, 4'b0000);
        rst = 1'b0;
        cyc = 4'b1001;
        stb = 4'b1001;
        next_cycle();
        @(negedge clk);
        check("post_rst_rr", a_grant, 4'b0001);
        check("post_rst_fp", b_grant, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
